// File: rtl/skid_reg_if.sv
// Valid/ready handshake bundle for skid_reg: upstream word in, downstream word out,
// plus the occupancy count. master is the environment side, slave is the stage.
interface skid_reg_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           occupancy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/skid_reg.sv
// Two-entry registered pipeline stage (main + skid register) with valid/ready handshake.
// Every output comes straight from a flop, so no combinational path crosses the stage.
module skid_reg #(
  parameter int DATAWIDTH = 8
) (
  input  logic      Clk,
  input  logic      Rst,
  skid_reg_if.slave bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [DATAWIDTH-1:0] main_q, main_d;
  logic [DATAWIDTH-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 accept;
  logic                 take;

  // in_ready_q starts at 0 after reset, so the first edge only raises it and accepts nothing.
  always_comb begin
    accept      = bus.in_valid & in_ready_q;
    take        = out_valid_q & bus.out_ready;
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = 1'b1;
    out_valid_d = out_valid_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d      = bus.in_data;
          out_valid_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (accept && take) begin
          main_d = bus.in_data;
        end else if (accept) begin
          skid_d     = bus.in_data;
          in_ready_d = 1'b0;
          state_d    = FULL;
        end else if (take) begin
          out_valid_d = 1'b0;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        in_ready_d = 1'b0;
        if (take) begin
          main_d     = skid_q;
          in_ready_d = 1'b1;
          state_d    = BUSY;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = EMPTY;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;
  assign bus.out_valid = out_valid_q;
  assign bus.occupancy = state_q;

endmodule

// File: tb/tb_skid_reg.sv
// Self-checking bench for skid_reg: directed scenarios followed by random traffic,
// compared each cycle against a queue-based FIFO reference model.
module tb_skid_reg;

  logic Clk;
  logic Rst;
  int   checks;
  int   failures;

  skid_reg_if #(.DATAWIDTH(8)) bus ();

  skid_reg #(.DATAWIDTH(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: an ordered queue of at most two words plus the last word shown.
  logic [7:0] model_q[$];
  logic [7:0] last_out;
  logic       started;

  function automatic void model_reset();
    model_q.delete();
    last_out = 8'h00;
    started  = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input logic [7:0] d, input logic r);
    logic acc;
    logic tk;
    acc = v && started && (model_q.size() < 2);
    tk  = (model_q.size() > 0) && r;
    if (tk) last_out = model_q.pop_front();
    if (acc) model_q.push_back(d);
    if (model_q.size() > 0) last_out = model_q[0];
    started = 1'b1;
  endfunction

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, model_q.size() > 0});
    compare({tag, ".out_data"}, bus.out_data, (model_q.size() > 0) ? model_q[0] : last_out);
    compare({tag, ".in_ready"}, {7'd0, bus.in_ready}, {7'd0, started && (model_q.size() < 2)});
    compare({tag, ".occupancy"}, {6'd0, bus.occupancy}, 8'(model_q.size()));
  endtask

  // Called at a falling edge: check, drive, clock once, land on the next falling edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [7:0] d, input logic r);
    checkOutput(tag);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge Clk);
    model_edge(v, d, r);
    @(negedge Clk);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    Rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset held for three clocks, then release and let in_ready rise.
    repeat (3) @(negedge Clk);
    checkOutput("reset");
    Rst = 1'b1;
    applyStimulus("rel", 1'b1, 8'h77, 1'b1);
    checkOutput("post_rel");

    // Streaming at full rate.
    applyStimulus("s1", 1'b1, 8'h11, 1'b1);
    applyStimulus("s2", 1'b1, 8'h22, 1'b1);
    applyStimulus("s3", 1'b1, 8'h33, 1'b1);
    applyStimulus("s4", 1'b0, 8'h99, 1'b1);

    // Back-pressure fills both entries.
    applyStimulus("bp1", 1'b1, 8'hA5, 1'b0);
    applyStimulus("bp2", 1'b1, 8'h5A, 1'b0);

    // FULL must ignore input.
    for (int i = 0; i < 4; i++) applyStimulus("full", 1'b1, 8'hFF, 1'b0);

    // Release back-pressure: A5 then 5A.
    applyStimulus("dr1", 1'b0, 8'h00, 1'b1);
    applyStimulus("dr2", 1'b0, 8'h00, 1'b1);

    // Single word drains to empty; out_data holds 3C afterwards.
    applyStimulus("e1", 1'b1, 8'h3C, 1'b1);
    applyStimulus("e2", 1'b0, 8'h00, 1'b1);
    applyStimulus("e3", 1'b0, 8'h00, 1'b0);

    // Async reset while FULL, asserted between edges.
    applyStimulus("ar1", 1'b1, 8'h01, 1'b0);
    applyStimulus("ar2", 1'b1, 8'h02, 1'b0);
    checkOutput("ar_full");
    #2 Rst = 1'b0;
    #1 model_reset();
    checkOutput("ar_now");
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("ar_post", 1'b0, 8'h00, 1'b1);

    // Random traffic with mixed valid/ready densities.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 3) != 0),
                    8'($urandom),
                    1'($urandom_range(0, 2) != 0));
    end
    checkOutput("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
